alu_core: RTL and testbench

Parametrised, multi-cycle arithmetic/logic execution core for the CPU datapath. It holds two operand registers loaded from a shared `data_in` bus and executes a 4-bit opcode on them. Single-cycle logic and add operations complete in one cycle; a shift-add multiply completes in WIDTH cycles. Results, carry and flags are registered and presented with a start/busy/done handshake to the CPU control sequencer.

---
 rtl/alu_core_if.sv | 28 ++
 rtl/alu_core.sv | 122 ++++++++++++
 tb/tb_alu_core.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_core_if.sv
// rtl/alu_core_if.sv - operand, launch and result signals of alu_core
interface alu_core_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             opsel;
  logic [3:0]       opcode;
  logic             cin;
  logic             start;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] data_hi;
  logic             cout;
  logic             zero;
  logic             illegal;
  logic             busy;
  logic             done;

  modport master (
    output data_in, load, opsel, opcode, cin, start,
    input  data_out, data_hi, cout, zero, illegal, busy, done
  );

  modport slave (
    input  data_in, load, opsel, opcode, cin, start,
    output data_out, data_hi, cout, zero, illegal, busy, done
  );
endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - multi-cycle ALU with operand registers and shift-add multiply
module alu_core #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  alu_core_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   a, b, mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   data_out, data_hi;
  logic               cout, zero, illegal, busy, done;

  logic [WIDTH:0]     ext;
  logic               ill;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  // Single-cycle result: ext[WIDTH] is the carry/shift-out bit.
  always_comb begin
    ext = '0;
    ill = 1'b0;
    case (bus.opcode)
      4'd0: ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, bus.cin};
      4'd1: ext = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
      4'd2: ext = {1'b0, a & b};
      4'd3: ext = {1'b0, a | b};
      4'd4: ext = {1'b0, a ^ b};
      4'd5: ext = {1'b0, ~a};
      4'd6: ext = {a, bus.cin};
      4'd7: ext = {a[0], bus.cin, a[WIDTH-1:1]};
      4'd8: ext = '0;
      default: ill = 1'b1;
    endcase
  end

  // One shift-add step; the adder carry shifts into the accumulator msb.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a        <= '0;
      b        <= '0;
      mcand    <= '0;
      acc      <= '0;
      cnt      <= '0;
      data_out <= '0;
      data_hi  <= '0;
      cout     <= 1'b0;
      zero     <= 1'b0;
      illegal  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load) begin
            if (bus.opsel) b <= bus.data_in;
            else           a <= bus.data_in;
          end
          if (bus.start) begin
            busy <= 1'b1;
            if (bus.opcode == OP_MUL) begin
              // Multiplicand is captured so a same-cycle load of B cannot alter it.
              acc   <= {{WIDTH{1'b0}}, a};
              mcand <= b;
              cnt   <= CW'(WIDTH - 1);
              state <= MUL;
            end else begin
              data_out <= ext[WIDTH-1:0];
              data_hi  <= '0;
              cout     <= ext[WIDTH];
              zero     <= (ext[WIDTH-1:0] == '0);
              illegal  <= ill;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
        end
        MUL: begin
          acc <= mul_next;
          if (cnt == '0) begin
            data_out <= mul_next[WIDTH-1:0];
            data_hi  <= mul_next[2*WIDTH-1:WIDTH];
            cout     <= 1'b0;
            zero     <= (mul_next == '0);
            illegal  <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_out = data_out;
  assign bus.data_hi  = data_hi;
  assign bus.cout     = cout;
  assign bus.zero     = zero;
  assign bus.illegal  = illegal;
  assign bus.busy     = busy;
  assign bus.done     = done;
endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - directed self-checking bench for alu_core
module tb_alu_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  alu_core_if #(.WIDTH(8)) bus ();

  alu_core #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic do_load(input logic sel, input logic [7:0] v);
    @(negedge clk);
    bus.load = 1'b1; bus.opsel = sel; bus.data_in = v;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic launch(input logic [3:0] op, input logic c);
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = op; bus.cin = c;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n, output logic busy_ok);
    n = 0;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    total++;
    if ({bus.data_out, bus.data_hi, bus.cout, bus.zero, bus.illegal, bus.busy, bus.done} !== 21'd0)
      $display("FAIL reset_outputs got=%h want=0",
               {bus.data_out, bus.data_hi, bus.cout, bus.zero, bus.illegal, bus.busy, bus.done});
    else passed++;
  endtask

  task automatic test_add;
    do_load(1'b0, 8'hF0);
    do_load(1'b1, 8'h20);
    launch(4'd0, 1'b1);
    total++;
    if ({bus.done, bus.busy, bus.data_out, bus.cout, bus.zero, bus.data_hi} !== {1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 8'h00})
      $display("FAIL add got done=%b busy=%b out=%h c=%b z=%b hi=%h want 1 1 11 1 0 00",
               bus.done, bus.busy, bus.data_out, bus.cout, bus.zero, bus.data_hi);
    else passed++;
    @(negedge clk);
    total++;
    if ({bus.done, bus.busy} !== 2'b00)
      $display("FAIL add_done_width got done=%b busy=%b want 0 0", bus.done, bus.busy);
    else passed++;
  endtask

  task automatic test_sub;
    do_load(1'b0, 8'h05);
    do_load(1'b1, 8'h05);
    launch(4'd1, 1'b0);
    total++;
    if ({bus.data_out, bus.cout, bus.zero} !== {8'h00, 1'b1, 1'b1})
      $display("FAIL sub_equal got out=%h c=%b z=%b want 00 1 1", bus.data_out, bus.cout, bus.zero);
    else passed++;
    do_load(1'b0, 8'h04);
    launch(4'd1, 1'b1);
    total++;
    if ({bus.data_out, bus.cout, bus.zero} !== {8'hFF, 1'b0, 1'b0})
      $display("FAIL sub_borrow got out=%h c=%b z=%b want ff 0 0", bus.data_out, bus.cout, bus.zero);
    else passed++;
  endtask

  task automatic test_logic;
    logic [3:0] ops  [6] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    logic       cins [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] outs [6] = '{8'h00, 8'hDB, 8'hDB, 8'h7E, 8'h03, 8'h40};
    logic       couts[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       zeros[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    do_load(1'b0, 8'h81);
    do_load(1'b1, 8'h5A);
    for (int i = 0; i < 6; i++) begin
      launch(ops[i], cins[i]);
      total++;
      if ({bus.data_out, bus.cout, bus.zero, bus.done} !== {outs[i], couts[i], zeros[i], 1'b1})
        $display("FAIL logic_op%0d got out=%h c=%b z=%b d=%b want %h %b %b 1", ops[i],
                 bus.data_out, bus.cout, bus.zero, bus.done, outs[i], couts[i], zeros[i]);
      else passed++;
    end
  endtask

  task automatic test_mul;
    int   n;
    logic busy_ok;
    do_load(1'b0, 8'hFF);
    do_load(1'b1, 8'hFF);
    launch(4'd8, 1'b0);
    wait_done(n, busy_ok);
    total++;
    if (n !== 8 || busy_ok !== 1'b1)
      $display("FAIL mul_latency got cycles=%0d busy_ok=%b want 8 1", n, busy_ok);
    else passed++;
    total++;
    if ({bus.data_hi, bus.data_out, bus.cout, bus.zero} !== {16'hFE01, 1'b0, 1'b0})
      $display("FAIL mul_ffxff got %h%h c=%b z=%b want fe01 0 0", bus.data_hi, bus.data_out, bus.cout, bus.zero);
    else passed++;
    @(negedge clk);
    total++;
    if ({bus.done, bus.busy} !== 2'b00)
      $display("FAIL mul_done_width got done=%b busy=%b want 0 0", bus.done, bus.busy);
    else passed++;
    do_load(1'b0, 8'h0F);
    do_load(1'b1, 8'h11);
    launch(4'd8, 1'b0);
    wait_done(n, busy_ok);
    total++;
    if ({bus.data_hi, bus.data_out} !== 16'h00FF || n !== 8)
      $display("FAIL mul_0fx11 got %h%h cycles=%0d want 00ff 8", bus.data_hi, bus.data_out, n);
    else passed++;
  endtask

  task automatic test_busy_ignore;
    int   n;
    logic busy_ok;
    launch(4'd8, 1'b0);
    @(negedge clk);
    bus.load = 1'b1; bus.opsel = 1'b0; bus.data_in = 8'h55;
    bus.start = 1'b1; bus.opcode = 4'd0;
    @(negedge clk);
    bus.load = 1'b0; bus.start = 1'b0;
    wait_done(n, busy_ok);
    total++;
    if ({bus.data_hi, bus.data_out} !== 16'h00FF || n !== 6)
      $display("FAIL busy_ignore_mul got %h%h cycles=%0d want 00ff 6", bus.data_hi, bus.data_out, n);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({bus.done, bus.busy} !== 2'b00)
      $display("FAIL busy_ignore_no_launch got done=%b busy=%b want 0 0", bus.done, bus.busy);
    else passed++;
    launch(4'd0, 1'b0);
    total++;
    if ({bus.data_out, bus.data_hi} !== {8'h20, 8'h00})
      $display("FAIL busy_ignore_a_kept got out=%h hi=%h want 20 00", bus.data_out, bus.data_hi);
    else passed++;
  endtask

  task automatic test_load_start_same;
    do_load(1'b0, 8'h01);
    do_load(1'b1, 8'h02);
    @(negedge clk);
    bus.load = 1'b1; bus.opsel = 1'b0; bus.data_in = 8'h10;
    bus.start = 1'b1; bus.opcode = 4'd0; bus.cin = 1'b0;
    @(negedge clk);
    bus.load = 1'b0; bus.start = 1'b0;
    total++;
    if (bus.data_out !== 8'h03)
      $display("FAIL load_start_preload got out=%h want 03", bus.data_out);
    else passed++;
    launch(4'd0, 1'b0);
    total++;
    if (bus.data_out !== 8'h12)
      $display("FAIL load_start_loaded got out=%h want 12", bus.data_out);
    else passed++;
  endtask

  task automatic test_illegal;
    launch(4'hB, 1'b1);
    total++;
    if ({bus.illegal, bus.data_out, bus.data_hi, bus.cout, bus.zero, bus.done} !== {1'b1, 16'h0000, 1'b0, 1'b1, 1'b1})
      $display("FAIL illegal_op got ill=%b out=%h hi=%h c=%b z=%b d=%b want 1 00 00 0 1 1",
               bus.illegal, bus.data_out, bus.data_hi, bus.cout, bus.zero, bus.done);
    else passed++;
    launch(4'd0, 1'b0);
    total++;
    if ({bus.illegal, bus.data_out} !== {1'b0, 8'h12})
      $display("FAIL illegal_clear got ill=%b out=%h want 0 12", bus.illegal, bus.data_out);
    else passed++;
  endtask

  task automatic test_reset_mid_mul;
    logic saw_done;
    do_load(1'b0, 8'hFF);
    do_load(1'b1, 8'hFF);
    launch(4'd8, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus.data_out, bus.data_hi, bus.cout, bus.zero, bus.illegal, bus.busy, bus.done} !== 21'd0)
      $display("FAIL reset_mid_mul got=%h want=0",
               {bus.data_out, bus.data_hi, bus.cout, bus.zero, bus.illegal, bus.busy, bus.done});
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    total++;
    if (saw_done !== 1'b0)
      $display("FAIL reset_no_done got done pulse=%b want 0", saw_done);
    else passed++;
    launch(4'd0, 1'b0);
    total++;
    if ({bus.data_out, bus.zero, bus.done} !== {8'h00, 1'b1, 1'b1})
      $display("FAIL reset_then_add got out=%h z=%b d=%b want 00 1 1", bus.data_out, bus.zero, bus.done);
    else passed++;
  endtask

  initial begin
    bus.data_in = '0; bus.load = 1'b0; bus.opsel = 1'b0;
    bus.opcode = '0; bus.cin = 1'b0; bus.start = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_add();
    test_sub();
    test_logic();
    test_mul();
    test_busy_ignore();
    test_load_start_same();
    test_illegal();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
